// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard and forwarding controller: per-operand bypass selection, load-use and
// condition-flag stalls, and a countdown scoreboard for one multi-cycle (mul/div) unit.
module hazard_scoreboard #(
  parameter int AW         = 5,
  parameter int NFWD       = 3,
  parameter int LATW       = 5,
  parameter int COND_DEPTH = 1,
  parameter int ZERO_HW    = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        d_valid,
  input  logic                        d_flush,
  input  logic [AW-1:0]               d_ra,
  input  logic [AW-1:0]               d_rb,
  input  logic                        d_need_ra,
  input  logic                        d_need_rb,
  input  logic                        d_wreg,
  input  logic [AW-1:0]               d_rn,
  input  logic                        d_mc,
  input  logic [LATW-1:0]             d_mc_lat,
  input  logic                        d_need_cond,
  input  logic [NFWD-1:0]             s_wreg,
  input  logic [NFWD*AW-1:0]          s_rn,
  input  logic [NFWD-1:0]             s_ready,
  input  logic [NFWD-1:0]             s_setcond,
  output logic                        d_available,
  output logic [$clog2(NFWD+1)-1:0]   fwd_q1,
  output logic [$clog2(NFWD+1)-1:0]   fwd_q2,
  output logic                        mc_busy,
  output logic                        mc_done,
  output logic [AW-1:0]               mc_rn,
  output logic [31:0]                 stall_cnt
);

  localparam int FW = $clog2(NFWD + 1);

  typedef struct packed {
    logic [FW-1:0] sel;
    logic          stall;
  } fwd_t;

  logic [LATW-1:0] cnt;
  fwd_t            op_a, op_b;
  logic            live_a, live_b, live_d;
  logic            cond_stall, mc_stall, any_stall, issue;

  function automatic logic live(input logic need, input logic [AW-1:0] r);
    return need && !((ZERO_HW != 0) && (r == '0));
  endfunction

  // Scan oldest to youngest so the youngest matching stage overwrites and wins; a not-ready
  // youngest match stalls rather than letting an older ready copy bypass past it.
  function automatic fwd_t resolve(input logic need, input logic [AW-1:0] r,
                                   input logic [NFWD-1:0] wreg, input logic [NFWD*AW-1:0] rn,
                                   input logic [NFWD-1:0] rdy);
    fwd_t f;
    f = '0;
    if (live(need, r)) begin
      for (int k = NFWD - 1; k >= 0; k--) begin
        if (wreg[k] && (rn[k*AW +: AW] == r)) begin
          f.sel   = FW'(k + 1);
          f.stall = ~rdy[k];
        end
      end
    end
    return f;
  endfunction

  assign mc_busy = (cnt != '0);
  assign mc_done = (cnt == LATW'(1));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    op_a       = resolve(d_need_ra, d_ra, s_wreg, s_rn, s_ready);
    op_b       = resolve(d_need_rb, d_rb, s_wreg, s_rn, s_ready);
    live_a     = live(d_need_ra, d_ra);
    live_b     = live(d_need_rb, d_rb);
    live_d     = live(d_wreg, d_rn);
    cond_stall = d_need_cond && (|s_setcond[COND_DEPTH-1:0]);
    mc_stall   = 1'b0;
    if (mc_busy) begin
      mc_stall = (live_a && (d_ra == mc_rn)) || (live_b && (d_rb == mc_rn)) ||
                 (live_d && (d_rn == mc_rn)) || d_mc;
    end
    any_stall   = d_valid && (op_a.stall || op_b.stall || cond_stall || mc_stall);
    d_available = ~any_stall;
    fwd_q1      = op_a.sel;
    fwd_q2      = op_b.sel;
    issue       = d_valid && d_available && !d_flush;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      mc_rn     <= '0;
      stall_cnt <= '0;
    end else begin
      // A flush in D never cancels an operation already in flight.
      if (cnt != '0) begin
        cnt <= cnt - LATW'(1);
      end else if (issue && d_mc) begin
        cnt   <= (d_mc_lat == '0) ? LATW'(1) : d_mc_lat;
        mc_rn <= d_rn;
      end
      if (any_stall && !d_flush && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

endmodule
